regfile_writeback: RTL and testbench

Write-back arbiter that owns the write port of the 8 x 16-bit general register file. It accepts results from two producers, the ALU and the load path, over valid/ready handshakes, and buffers one entry per source. It arbitrates round-robin and drives a registered single-cycle write (`reg_write_en`/`reg_write_dest`/`reg_write_data`) into the register file. It also exports a pending-destination mask for hazard detection in the issue stage.

---
 rtl/regfile_writeback.sv | 111 +++++++++++
 tb/tb_regfile_writeback.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback
//   Owns the write port of the 8 x 16-bit register file. Buffers one result
//   per producer (ALU, load path) in a slot register, arbitrates round-robin
//   between the two slots and issues a registered single-cycle write.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   alu_valid/ready/dest/data    ALU result handshake
//   ld_valid/ready/dest/data     load result handshake
//   reg_write_en/dest/data       registered write strobe into the register file
//   pending_mask                 one bit per register with a write held here
module regfile_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [ADDR_W-1:0]      alu_dest,
    input  logic [DATA_W-1:0]      alu_data,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [ADDR_W-1:0]      ld_dest,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   reg_write_en,
    output logic [ADDR_W-1:0]      reg_write_dest,
    output logic [DATA_W-1:0]      reg_write_data,
    output logic [2**ADDR_W-1:0]   pending_mask
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_LD  = 1'b1;

    logic              alu_slot_valid;
    logic [ADDR_W-1:0] alu_slot_dest;
    logic [DATA_W-1:0] alu_slot_data;
    logic              ld_slot_valid;
    logic [ADDR_W-1:0] ld_slot_dest;
    logic [DATA_W-1:0] ld_slot_data;
    logic              last_grant;
    logic              grant_alu;
    logic              grant_ld;

    // On a tie the source that did not win last time is served.
    always_comb begin
        grant_alu = alu_slot_valid && (!ld_slot_valid || last_grant == GRANT_LD);
        grant_ld  = ld_slot_valid && (!alu_slot_valid || last_grant == GRANT_ALU);
    end

    // A slot that drains this cycle can be refilled in the same edge.
    assign alu_ready = !alu_slot_valid || grant_alu;
    assign ld_ready  = !ld_slot_valid || grant_ld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_slot_valid <= 1'b0;
            alu_slot_dest  <= '0;
            alu_slot_data  <= '0;
        end else if (alu_valid && alu_ready) begin
            alu_slot_valid <= 1'b1;
            alu_slot_dest  <= alu_dest;
            alu_slot_data  <= alu_data;
        end else if (grant_alu) begin
            alu_slot_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_slot_valid <= 1'b0;
            ld_slot_dest  <= '0;
            ld_slot_data  <= '0;
        end else if (ld_valid && ld_ready) begin
            ld_slot_valid <= 1'b1;
            ld_slot_dest  <= ld_dest;
            ld_slot_data  <= ld_data;
        end else if (grant_ld) begin
            ld_slot_valid <= 1'b0;
        end
    end

    // Output register: dest/data hold their last value when no write issues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
            last_grant     <= GRANT_LD;
        end else begin
            reg_write_en <= grant_alu || grant_ld;
            if (grant_alu) begin
                reg_write_dest <= alu_slot_dest;
                reg_write_data <= alu_slot_data;
                last_grant     <= GRANT_ALU;
            end else if (grant_ld) begin
                reg_write_dest <= ld_slot_dest;
                reg_write_data <= ld_slot_data;
                last_grant     <= GRANT_LD;
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        if (alu_slot_valid) pending_mask[alu_slot_dest] = 1'b1;
        if (ld_slot_valid)  pending_mask[ld_slot_dest]  = 1'b1;
        if (reg_write_en)   pending_mask[reg_write_dest] = 1'b1;
    end

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [2:0]  alu_dest;
    logic [15:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [2:0]  ld_dest;
    logic [15:0] ld_data;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  pending_mask;

    regfile_writeback #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dest(alu_dest), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_dest(ld_dest), .ld_data(ld_data),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .pending_mask(pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each producer is a queue of at most one pending result; the output is
    // whichever queue head was chosen last cycle.
    typedef struct packed { logic [2:0] d; logic [15:0] v; } ent_t;
    typedef struct { logic [2:0] d; logic [15:0] v; int c; } wl_t;

    ent_t qa[$];
    ent_t ql[$];
    bit          m_en;
    logic [2:0]  m_dest;
    logic [15:0] m_data;
    bit          prefer_alu;
    wl_t         wlog[$];
    int          cyc = 0;

    always @(negedge clk) begin
        bit ga, gl, ra, rl;
        logic [7:0] em;
        ent_t e;
        wl_t w;
        cyc++;
        if (!rst_n) begin
            qa.delete(); ql.delete();
            m_en = 0; m_dest = '0; m_data = '0; prefer_alu = 1;
        end
        if (qa.size() != 0 && ql.size() != 0) begin
            ga = prefer_alu; gl = !prefer_alu;
        end else begin
            ga = (qa.size() != 0); gl = (ql.size() != 0);
        end
        ra = (qa.size() == 0) || ga;
        rl = (ql.size() == 0) || gl;
        em = 8'h00;
        if (qa.size() != 0) em = em | (8'h01 << qa[0].d);
        if (ql.size() != 0) em = em | (8'h01 << ql[0].d);
        if (m_en) em = em | (8'h01 << m_dest);

        chk("cyc_en", {31'd0, reg_write_en}, {31'd0, m_en});
        chk("cyc_dest", {29'd0, reg_write_dest}, {29'd0, m_dest});
        chk("cyc_data", {16'd0, reg_write_data}, {16'd0, m_data});
        chk("cyc_mask", {24'd0, pending_mask}, {24'd0, em});
        chk("cyc_alu_ready", {31'd0, alu_ready}, {31'd0, ra});
        chk("cyc_ld_ready", {31'd0, ld_ready}, {31'd0, rl});

        if (reg_write_en) begin
            w.d = reg_write_dest; w.v = reg_write_data; w.c = cyc;
            wlog.push_back(w);
        end

        if (rst_n) begin
            if (ga) begin
                m_en = 1; m_dest = qa[0].d; m_data = qa[0].v;
                void'(qa.pop_front()); prefer_alu = 0;
            end else if (gl) begin
                m_en = 1; m_dest = ql[0].d; m_data = ql[0].v;
                void'(ql.pop_front()); prefer_alu = 1;
            end else begin
                m_en = 0;
            end
            if (alu_valid && ra) begin e.d = alu_dest; e.v = alu_data; qa.push_back(e); end
            if (ld_valid && rl)  begin e.d = ld_dest;  e.v = ld_data;  ql.push_back(e); end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        alu_valid = 0; ld_valid = 0;
        rst_n = 0;
        tick; tick;
        rst_n = 1;
        wlog.delete();
    endtask

    logic [2:0]  sa_d[8];
    logic [15:0] sa_v[8];
    logic [2:0]  sl_d[8];
    logic [15:0] sl_v[8];
    int ld_stall;

    task automatic run_streams(input int na, input int nl);
        int ia, il, n;
        bit ha, hl;
        ia = 0; il = 0; n = 0; ld_stall = 0;
        while ((ia < na || il < nl) && n < 60) begin
            alu_valid = (ia < na);
            if (ia < na) begin alu_dest = sa_d[ia]; alu_data = sa_v[ia]; end
            ld_valid = (il < nl);
            if (il < nl) begin ld_dest = sl_d[il]; ld_data = sl_v[il]; end
            @(negedge clk);
            ha = alu_valid && alu_ready;
            hl = ld_valid && ld_ready;
            if (ld_valid && !ld_ready) ld_stall++;
            tick;
            if (ha) ia++;
            if (hl) il++;
            n++;
        end
        alu_valid = 0; ld_valid = 0;
        if (n >= 60) chk("stream_timeout", n, 0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        rst_n = 0;
        alu_valid = 0; alu_dest = '0; alu_data = '0;
        ld_valid = 0;  ld_dest = '0;  ld_data = '0;
        tick;
        chk("rst_en", {31'd0, reg_write_en}, 0);
        chk("rst_mask", {24'd0, pending_mask}, 0);
        chk("rst_dest", {29'd0, reg_write_dest}, 0);
        chk("rst_data", {16'd0, reg_write_data}, 0);
        tick;
        rst_n = 1;
        wlog.delete();

        // single ALU write, r3 = 0x1234
        alu_valid = 1; alu_dest = 3'd3; alu_data = 16'h1234;
        tick;
        alu_valid = 0;
        chk("t1_mask_c1", {24'd0, pending_mask}, 32'h08);
        chk("t1_en_c1", {31'd0, reg_write_en}, 0);
        tick;
        chk("t1_en_c2", {31'd0, reg_write_en}, 1);
        chk("t1_dest_c2", {29'd0, reg_write_dest}, 3);
        chk("t1_data_c2", {16'd0, reg_write_data}, 32'h1234);
        chk("t1_mask_c2", {24'd0, pending_mask}, 32'h08);
        tick;
        chk("t1_en_c3", {31'd0, reg_write_en}, 0);
        chk("t1_mask_c3", {24'd0, pending_mask}, 0);

        // both sources streaming: strict alternation, ALU first
        do_reset;
        for (int i = 0; i < 4; i++) begin
            sa_d[i] = 3'd1; sa_v[i] = 16'hAAAA + 16'(i);
            sl_d[i] = 3'd2; sl_v[i] = 16'h5555 + 16'(i);
        end
        run_streams(4, 4);
        repeat (4) tick;
        chk("t2_count", wlog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < wlog.size()) begin
                chk("t2_dest", {29'd0, wlog[i].d}, (i % 2 == 0) ? 32'd1 : 32'd2);
                chk("t2_data", {16'd0, wlog[i].v},
                    (i % 2 == 0) ? 32'hAAAA + 32'(i / 2) : 32'h5555 + 32'(i / 2));
            end
        end

        // load-only stream, dest 0..7 back to back
        do_reset;
        for (int i = 0; i < 8; i++) begin
            sl_d[i] = 3'(i); sl_v[i] = 16'h0100 + 16'(i);
        end
        run_streams(0, 8);
        repeat (3) tick;
        chk("t3_ld_ready", ld_stall, 0);
        chk("t3_count", wlog.size(), 8);
        if (wlog.size() == 8) begin
            chk("t3_consecutive", wlog[7].c - wlog[0].c, 7);
            for (int i = 0; i < 8; i++) begin
                chk("t3_dest", {29'd0, wlog[i].d}, i);
                chk("t3_data", {16'd0, wlog[i].v}, 32'h0100 + i);
            end
        end

        // back-pressure: ALU slot held while LD wins
        do_reset;
        alu_valid = 1; alu_dest = 3'd4; alu_data = 16'h1111;
        ld_valid = 1;  ld_dest = 3'd6;  ld_data = 16'h2222;
        tick;
        alu_dest = 3'd4; alu_data = 16'h3333;
        ld_valid = 0;
        tick;
        chk("t4_alu_ready_low", {31'd0, alu_ready}, 0);
        alu_dest = 3'd7; alu_data = 16'h4444;
        tick;
        alu_valid = 0;
        repeat (3) tick;
        chk("t4_count", wlog.size(), 3);
        if (wlog.size() == 3) begin
            chk("t4_w0", {13'd0, wlog[0].d, wlog[0].v}, {13'd0, 3'd4, 16'h1111});
            chk("t4_w1", {13'd0, wlog[1].d, wlog[1].v}, {13'd0, 3'd6, 16'h2222});
            chk("t4_w2", {13'd0, wlog[2].d, wlog[2].v}, {13'd0, 3'd4, 16'h3333});
        end

        // asynchronous reset in the middle of traffic
        do_reset;
        alu_valid = 1; alu_dest = 3'd1; alu_data = 16'h0A0A;
        ld_valid = 1;  ld_dest = 3'd2;  ld_data = 16'h0B0B;
        tick;
        alu_dest = 3'd3; alu_data = 16'h0C0C;
        ld_dest = 3'd4;  ld_data = 16'h0D0D;
        tick;
        chk("t5_pre_en", {31'd0, reg_write_en}, 1);
        chk("t5_pre_mask", {24'd0, pending_mask}, 32'h0E);
        #2;
        rst_n = 0;
        #1;
        chk("t5_async_en", {31'd0, reg_write_en}, 0);
        chk("t5_async_mask", {24'd0, pending_mask}, 0);
        chk("t5_async_dest", {29'd0, reg_write_dest}, 0);
        chk("t5_async_data", {16'd0, reg_write_data}, 0);
        alu_valid = 0; ld_valid = 0;
        tick; tick;
        rst_n = 1;
        wlog.delete();
        chk("t5_alu_ready", {31'd0, alu_ready}, 1);
        chk("t5_ld_ready", {31'd0, ld_ready}, 1);
        repeat (4) tick;
        chk("t5_no_writes", wlog.size(), 0);

        // same destination from both sources
        do_reset;
        alu_valid = 1; alu_dest = 3'd5; alu_data = 16'h0001;
        ld_valid = 1;  ld_dest = 3'd5;  ld_data = 16'h0002;
        tick;
        alu_valid = 0; ld_valid = 0;
        chk("t6_mask_c1", {24'd0, pending_mask}, 32'h20);
        tick;
        chk("t6_mask_c2", {24'd0, pending_mask}, 32'h20);
        tick;
        chk("t6_mask_c3", {24'd0, pending_mask}, 32'h20);
        tick;
        chk("t6_mask_c4", {24'd0, pending_mask}, 0);
        chk("t6_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("t6_first", {13'd0, wlog[0].d, wlog[0].v}, {13'd0, 3'd5, 16'h0001});
            chk("t6_second", {13'd0, wlog[1].d, wlog[1].v}, {13'd0, 3'd5, 16'h0002});
        end

        repeat (2) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
